// File: rtl/fft_frame_scheduler_if.sv
// Streaming handshake and status bundle between the upstream source, the
// frame scheduler and the first FFT stage.
interface fft_frame_scheduler_if;
    logic               s_valid;
    logic               s_ready;
    logic               s_last;
    logic signed [31:0] s_real;
    logic signed [31:0] s_img;
    logic               st_start;
    logic               st_end;
    logic signed [31:0] st_real;
    logic signed [31:0] st_img;
    logic               pipe_last;
    logic        [2:0]  inflight;
    logic        [15:0] frame_cnt;
    logic               underrun;
    logic               len_err;
    logic               cnt_err;

    modport master (
        input  s_valid, s_last, s_real, s_img, pipe_last,
        output s_ready, st_start, st_end, st_real, st_img,
               inflight, frame_cnt, underrun, len_err, cnt_err
    );

    modport slave (
        output s_valid, s_last, s_real, s_img, pipe_last,
        input  s_ready, st_start, st_end, st_real, st_img,
               inflight, frame_cnt, underrun, len_err, cnt_err
    );
endinterface

// File: rtl/fft_frame_scheduler.sv
// Cuts an upstream sample stream into fixed N-sample frames for FFT stage 0,
// enforces the inter-frame gap and tracks frames in flight.
module fft_frame_scheduler #(
    parameter int LOG2N        = 5,
    parameter int GAP          = 2,
    parameter int MAX_INFLIGHT = 2
) (
    input logic              clk,
    input logic              rst,
    fft_frame_scheduler_if.master bus
);
    localparam int                DATA_W = 32;
    localparam logic [LOG2N-1:0]  K_LAST = '1;
    localparam logic [3:0]        GAP_M1 = 4'(GAP - 1);
    localparam logic [2:0]        MAX_IF = 3'(MAX_INFLIGHT);

    typedef enum logic [1:0] {IDLE, STREAM, GAPWAIT} state_t;

    state_t                    state;
    logic [LOG2N-1:0]          k;
    logic [3:0]                gcnt;
    logic [2:0]                inflight;
    logic [15:0]               frame_cnt;
    logic                      underrun_r;
    logic                      len_err_r;
    logic                      cnt_err_r;
    logic                      start_p1;
    logic                      end_p1;
    logic signed [DATA_W-1:0]  real_p1;
    logic signed [DATA_W-1:0]  img_p1;

    logic                      ready;
    logic                      accept;
    logic                      dec;
    logic                      at_last;
    logic                      sample_vld;
    logic [LOG2N-1:0]          k_in;

    function automatic logic signed [DATA_W-1:0] gate_sample(
        input logic                     keep,
        input logic signed [DATA_W-1:0] x
    );
        return keep ? x : '0;
    endfunction

    // k tracks the index of the sample currently on st_*; k_in is the beat arriving now.
    assign k_in       = k + LOG2N'(1);
    assign ready      = !rst && (state == STREAM || (state == IDLE && inflight < MAX_IF));
    assign accept     = (state == IDLE) && bus.s_valid && ready;
    assign at_last    = (state == STREAM) && (k_in == K_LAST);
    assign sample_vld = (accept || state == STREAM) && bus.s_valid;
    assign dec        = bus.pipe_last && (inflight != 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            gcnt       <= '0;
            inflight   <= '0;
            frame_cnt  <= '0;
            underrun_r <= 1'b0;
            len_err_r  <= 1'b0;
            cnt_err_r  <= 1'b0;
            start_p1   <= 1'b0;
            end_p1     <= 1'b0;
            real_p1    <= '0;
            img_p1     <= '0;
        end else begin
            // stage-0 output register
            start_p1 <= accept;
            end_p1   <= at_last;
            real_p1  <= gate_sample(sample_vld, bus.s_real);
            img_p1   <= gate_sample(sample_vld, bus.s_img);

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        k     <= '0;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    k <= k_in;
                    if (!bus.s_valid)
                        underrun_r <= 1'b1;
                    if ((bus.s_last && k_in != K_LAST) ||
                        (!bus.s_last && bus.s_valid && k_in == K_LAST))
                        len_err_r <= 1'b1;
                    if (at_last) begin
                        state <= GAPWAIT;
                        gcnt  <= GAP_M1;
                    end
                end
                GAPWAIT: begin
                    if (gcnt == 4'd0)
                        state <= IDLE;
                    else
                        gcnt <= gcnt - 4'd1;
                end
                default: state <= IDLE;
            endcase

            // A start and a retiring frame in the same cycle cancel out.
            unique case ({accept, dec})
                2'b10:   inflight <= inflight + 3'd1;
                2'b01:   inflight <= inflight - 3'd1;
                default: ;
            endcase

            if (dec)
                frame_cnt <= frame_cnt + 16'd1;
            if (bus.pipe_last && inflight == 3'd0)
                cnt_err_r <= 1'b1;
        end
    end

    assign bus.s_ready   = ready;
    assign bus.st_start  = start_p1;
    assign bus.st_end    = end_p1;
    assign bus.st_real   = real_p1;
    assign bus.st_img    = img_p1;
    assign bus.inflight  = inflight;
    assign bus.frame_cnt = frame_cnt;
    assign bus.underrun  = underrun_r;
    assign bus.len_err   = len_err_r;
    assign bus.cnt_err   = cnt_err_r;
endmodule
